// File: rtl/bin_to_bcd_if.sv
// bin_to_bcd_if: request/result bundle between the converter and its user
//   start, bin_in                      : conversion request and binary operand
//   busy, done, BCD_code, valid_BCD,
//   overflow                           : converter status and registered result
interface bin_to_bcd_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   BCD_code;
    logic                  valid_BCD;
    logic                  overflow;
    modport master (output start, bin_in, input busy, done, BCD_code, valid_BCD, overflow);
    modport slave  (input start, bin_in, output busy, done, BCD_code, valid_BCD, overflow);
endinterface

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential double-dabble binary-to-BCD converter, one bit per clock
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of bin_to_bcd_if (start/bin_in in; busy/done/BCD_code/valid_BCD/overflow out)
module bin_to_bcd_converter #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input logic         clk,
    input logic         reset,
    bin_to_bcd_if.slave bus
);
    localparam int MAX_VAL = 10**DIGITS - 1;
    localparam int CW      = $clog2(BIN_WIDTH + 1);
    localparam int DW      = 4*DIGITS;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [DW-1:0]        scratch_q, scratch_d, adj, bcd_q, bcd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
    logic                 valid_q, valid_d, ovf_out_q, ovf_out_d;

    // add-3 correction on every digit that would overflow past 9 once doubled
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++)
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        ovf_out_d = ovf_out_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = SHIFT;
                shift_d   = bus.bin_in;
                scratch_d = '0;
                cnt_d     = CW'(BIN_WIDTH);
                ovf_d     = int'(bus.bin_in) > MAX_VAL;
                busy_d    = 1'b1;
            end
            SHIFT: begin
                // bits carried out of the top digit only occur for saturated inputs
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d                = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                state_d   = IDLE;
                bcd_d     = ovf_q ? {DIGITS{4'h9}} : scratch_q;
                ovf_out_d = ovf_q;
                valid_d   = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.BCD_code  = bcd_q;
    assign bus.valid_BCD = valid_q;
    assign bus.overflow  = ovf_out_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: self-checking bench for bin_to_bcd_converter
module tb_bin_to_bcd_converter;
    localparam int BW = 14;
    localparam int DG = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus ();
    bin_to_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [BW-1:0]   bin;
        logic [4*DG-1:0] bcd;
        logic            ovf;
    } vec_t;
    vec_t vecs[8];
    vec_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // scoreboard: every done pulse must match the oldest accepted request
    vec_t e;
    always @(negedge clk) begin
        if (reset && bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("sb_bcd", 32'(bus.BCD_code), 32'(e.bcd));
                check("sb_ovf", 32'(bus.overflow), 32'(e.ovf));
                check("sb_valid", 32'(bus.valid_BCD), 32'd1);
                check("sb_busy", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic wait_done(input int from, input string nm);
        int lat;
        lat = from;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(nm, lat, 15);
    endtask

    task automatic run_conv(input logic [BW-1:0] b, input logic [4*DG-1:0] x, input logic o);
        bus.start  = 1'b1;
        bus.bin_in = b;
        @(posedge clk);
        #1;
        exp_q.push_back('{b, x, o});
        bus.start = 1'b0;
        check("conv_busy", 32'(bus.busy), 32'd1);
        wait_done(0, "conv_latency");
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int d0;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{14'd1234,  16'h1234, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0};
        vecs[3] = '{14'd10000, 16'h9999, 1'b1};
        vecs[4] = '{14'd16383, 16'h9999, 1'b1};
        vecs[5] = '{14'd1,     16'h0001, 1'b0};
        vecs[6] = '{14'd5,     16'h0005, 1'b0};
        vecs[7] = '{14'd999,   16'h0999, 1'b0};

        bus.start  = 1'b1;
        bus.bin_in = 14'h2abc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.valid_BCD), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_bcd", 32'(bus.BCD_code), 32'h0);
        bus.start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

        // start during conversion is ignored and not queued
        d0 = done_cnt;
        bus.start  = 1'b1;
        bus.bin_in = 14'd7;
        @(posedge clk);
        #1;
        exp_q.push_back('{14'd7, 16'h0007, 1'b0});
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 14'd42;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(5, "ignore_latency");
        repeat (20) @(posedge clk);
        #1;
        check("ignore_single_done", done_cnt - d0, 32'd1);
        check("ignore_idle", 32'(bus.busy), 32'd0);

        // reset mid-conversion aborts without a done pulse
        d0 = done_cnt;
        bus.start  = 1'b1;
        bus.bin_in = 14'd4321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.valid_BCD), 32'd0);
        check("abort_bcd", 32'(bus.BCD_code), 32'h0);
        check("abort_ovf", 32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 32'd0);
        run_conv(14'd56, 16'h0056, 1'b0);

        // start held high: back-to-back conversions every BW+2 cycles
        bus.start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.bin_in = BW'(k);
            @(posedge clk);
            #1;
            exp_q.push_back('{BW'(k), 16'(k), 1'b0});
            check("held_busy", 32'(bus.busy), 32'd1);
            bus.bin_in = '1;
            repeat (7) @(posedge clk);
            #1;
            if (k > 1) check("held_stable", 32'(bus.BCD_code), 32'(k - 1));
            if (k == 3) bus.start = 1'b0;
            wait_done(7, "held_latency");
        end
        repeat (20) @(posedge clk);
        #1;
        check("held_no_extra", 32'(bus.busy), 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
